// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows stage feeding MixColumns over valid/ready.
// Define SUB_SHIFT_PARALLEL_EN to substitute all sixteen bytes in a single SUB cycle.
module sub_shift_rows (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  state_t       r_state;
  logic [127:0] r_work;
  logic         r_last;
  logic [127:0] r_out_state;
  logic         r_out_last;
  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic         w_accept;
  logic         w_sub_done;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign out_state = r_out_state;
  assign out_last  = r_out_last;

`ifdef SUB_SHIFT_PARALLEL_EN
  always_comb begin
    w_sub = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      w_sub[8*i +: 8] = sbox(r_work[8*i +: 8]);
    end
  end

  assign w_sub_done = 1'b1;
`else
  logic [1:0]  r_col;
  logic [31:0] w_col;
  logic [31:0] w_col_sub;

  // Column select and write-back use constant slices so only four S-boxes are built.
  always_comb begin
    w_col = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (r_col == 2'(c)) w_col = r_work[32*c +: 32];
    end
  end

  always_comb begin
    w_col_sub = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      w_col_sub[8*r +: 8] = sbox(w_col[8*r +: 8]);
    end
  end

  always_comb begin
    w_sub = r_work;
    for (int unsigned c = 0; c < 4; c++) begin
      if (r_col == 2'(c)) w_sub[32*c +: 32] = w_col_sub;
    end
  end

  assign w_sub_done = (r_col == 2'd3);
`endif

  always_comb begin
    w_shift = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        w_shift[32*c + 8*r +: 8] = w_sub[32*((c + r) % 4) + 8*r +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_last      <= 1'b0;
      r_out_state <= '0;
      r_out_last  <= 1'b0;
`ifndef SUB_SHIFT_PARALLEL_EN
      r_col       <= '0;
`endif
    end else if (w_accept) begin
      // Accept is only possible from IDLE or a completing DONE, giving back-to-back entry to SUB.
      r_work  <= in_state;
      r_last  <= in_last;
      r_state <= SUB;
`ifndef SUB_SHIFT_PARALLEL_EN
      r_col   <= '0;
`endif
    end else begin
      case (r_state)
        SUB: begin
          r_work <= w_sub;
`ifndef SUB_SHIFT_PARALLEL_EN
          r_col  <= r_col + 2'd1;
`endif
          if (w_sub_done) begin
            r_state     <= DONE;
            r_out_state <= w_shift;
            r_out_last  <= r_last;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift_rows.sv
// Scoreboard bench for sub_shift_rows against a GF(2^8)-derived AES reference model.
module tb_sub_shift_rows;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         out_last;

  always #5 clk = ~clk;

  sub_shift_rows dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_last  (out_last)
  );

  typedef struct {
    logic [127:0] s;
    logic         l;
    int           c;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         acc_log[$];
  int         hs_log[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         new_out = 1'b1;
  bit         drv_done = 1'b0;
  logic [7:0] sbox_ref [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference S-box: multiplicative inverse in GF(2^8) followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1b;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = '0;
      for (int x = 1; x < 256; x++) begin
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sbox_ref[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_ssr(input logic [127:0] s);
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_ref[s[8*i +: 8]];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c + r) +: 8] = b[4*((c + r) % 4) + r];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Monitor: checks latency on first sight of a result and data on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      new_out = 1'b1;
    end else if (out_valid) begin
      if (new_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got=%h exp=none", out_state);
        end else begin
          chk_int("latency", cyc - sb[0].c, 4);
        end
        new_out = 1'b0;
      end
      if (out_ready) begin
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("out_state", out_state, mon_e.s);
          chk("out_last", 128'(out_last), 128'(mon_e.l));
        end
        hs_log.push_back(cyc + 1);
        new_out = 1'b1;
      end
    end
  end

  task automatic send(input logic [127:0] s, input logic l);
    exp_t e;
    bit   acc;
    int   n;
    in_valid = 1'b1; in_state = s; in_last = l;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = ref_ssr(s); e.l = l; e.c = cyc + 1;
        sb.push_back(e);
        acc_log.push_back(cyc + 1);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] all63, appb_in, appb_out, rs, exp_bp;
    int           n;

    build_sbox();
    all63    = {16{8'h63}};
    appb_in  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
    appb_out = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, '0);
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    out_ready = 1'b1;
    send('0, 1'b0);
    wait_drain();
    chk("zero_state", out_state, all63);
    chk("zero_last", 128'(out_last), 128'(0));
    @(posedge clk); #1;

    send(appb_in, 1'b1);
    wait_drain();
    chk("appb_state", out_state, appb_out);
    chk("appb_last", 128'(out_last), 128'(1));
    @(posedge clk); #1;

    out_ready = 1'b0;
    rs = {$urandom, $urandom, $urandom, $urandom};
    exp_bp = ref_ssr(rs);
    send(rs, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_state", out_state, exp_bp);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release", 128'(out_valid), 128'(0));
    @(posedge clk); #1;

    acc_log.delete();
    hs_log.delete();
    send('0, 1'b0);
    send(appb_in, 1'b1);
    wait_drain();
    chk_int("b2b_count", hs_log.size(), 2);
    if (acc_log.size() >= 2 && hs_log.size() >= 1)
      chk_int("b2b_accept_in_done", acc_log[1], hs_log[0]);
    chk("b2b_last_state", out_state, appb_out);
    @(posedge clk); #1;

    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++)
          send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    @(posedge clk); #1;

    send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_state", out_state, '0);
    chk("midrst_last", 128'(out_last), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 8; i++) begin
      chk("midrst_no_valid", 128'(out_valid), 128'(0));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
